i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Audio sample serializer that sits directly downstream of the 16-word sample FIFO and drives the external I2S DAC.
- Pulls one mono sample per stereo frame from the FIFO read port and generates BCLK and LRCLK from the system clock.
- Shifts the sample out MSB-first on both channels in standard I2S format, with one BCLK of data delay after each LRCLK edge.
- Flags and counts underruns when the FIFO is empty at fetch time.

Parameters:
- WIDTH, 16: sample width; must match the FIFO word width.
- SLOT_BITS, 16: BCLK periods per channel slot; must be >= WIDTH. Frame length = 2*SLOT_BITS BCLK periods.
- BCLK_DIV, 4: CLK cycles per BCLK half-period; must be >= 2.

Ports:
- CLK  in  1  system clock; also clocks the FIFO read side (the FIFO registers DOUT on the falling edge of this clock).
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  run request.
- EMPTY  in  1  FIFO empty flag.
- DIN  in  WIDTH  FIFO DOUT.
- READ  out  1  FIFO read strobe, one CLK cycle wide.
- BCLK  out  1  I2S bit clock.
- LRCLK  out  1  word select; 0 = left slot, 1 = right slot.
- SDATA  out  1  I2S serial data.
- UNDERRUN  out  1  one-cycle pulse when a fetch finds the FIFO empty.
- UNDERRUN_CNT  out  8  saturating underrun count.

Behaviour:
- Clock and reset: single clock CLK; reset is synchronous and active-high on RESET.
- Reset state:
  - All outputs 0; UNDERRUN_CNT = 0.
  - Internal counters cleared, SAMPLE and shift register cleared, state = IDLE.
  - RESET mid-frame aborts the frame at the next CLK edge.
- State IDLE:
  - BCLK, LRCLK, SDATA held at 0; READ held at 0.
  - Moves to RUN on the CLK edge where ENABLE = 1, with DIV_CNT = 0 and BIT_CNT = 0.
- State RUN:
  - DIV_CNT counts 0..2*BCLK_DIV-1.
  - BIT_CNT (bit position in frame) counts 0..2*SLOT_BITS-1 and advances when DIV_CNT wraps.
  - BCLK = 0 while DIV_CNT < BCLK_DIV, else 1. Each bit period therefore starts with a BCLK falling edge.
  - LRCLK and SDATA change only at bit-period starts (DIV_CNT = 0), aligned with the BCLK falling edge.
  - LRCLK = 0 for BIT_CNT < SLOT_BITS, else 1.
- Stop: if ENABLE is low when BIT_CNT wraps 2*SLOT_BITS-1 -> 0, go to IDLE. A frame is never truncated by ENABLE.
- Fetch:
  - At BIT_CNT = 0, DIV_CNT = 0: if EMPTY = 0, assert READ for exactly that CLK cycle.
  - If EMPTY = 1: READ stays 0, SAMPLE is set to 0, UNDERRUN pulses for that cycle, and UNDERRUN_CNT increments, saturating at 255.
  - Capture DIN into the SAMPLE register 2 CLK cycles after the READ cycle. The capture is guaranteed before bit 1 because BCLK_DIV >= 2.
  - At most one READ per frame.
- Slot data:
  - SLOT_BITS-bit word = SAMPLE left-justified, zero-padded below the LSB.
  - The same word is used for the left and right slots (mono duplicated).
- Shift register:
  - Loaded from the slot data at bit-period start of BIT_CNT = 1 (left) and BIT_CNT = SLOT_BITS+1 (right).
  - Shifts MSB-first at every later bit-period start.
- I2S delay:
  - Slot-data bit j (j = 0 is MSB) appears on SDATA at frame position (slot_start + 1 + j) mod 2*SLOT_BITS.
  - Consequently, position 0 of each slot carries the last bit of the previous slot.
  - On the first frame after leaving IDLE, position 0 carries 0.
- Wrap and simultaneous events:
  - The right-slot LSB of the final frame before IDLE is dropped.
  - EMPTY is sampled only in the fetch cycle; changes elsewhere are ignored.
  - RESET takes priority over ENABLE and over the fetch.

Test Plan:
- Reset behaviour: RESET held 3 cycles, then ENABLE = 0 for 50 cycles -> all outputs 0, READ never asserted, UNDERRUN_CNT = 0.
- Basic frame: defaults except BCLK_DIV = 2; FIFO holds 16'hA5C3; ENABLE = 1 ->
  - READ pulses at cycle 0 of the frame; BCLK period = 4 CLK; LRCLK toggles every 64 CLK.
  - SDATA bits 1..15 = 1010010111000011 minus its last bit; the LSB (1) appears at bit 16.
  - The same pattern repeats in the right slot, with its LSB at bit 0 of the next frame.
- Underrun: FIFO empty at frame start ->
  - READ stays 0; UNDERRUN pulses for 1 cycle; UNDERRUN_CNT = 1.
  - SDATA = 0 for all bits except bit 0, which carries the prior right LSB.
  - 300 consecutive empty frames -> UNDERRUN_CNT saturates at 255.
- Stream ordering: 16'h0001, 16'h8000, 16'hFFFF queued ->
  - Three frames emit these samples in order, each duplicated L/R.
  - Exactly one READ per frame; the FIFO becomes EMPTY after the third read.
- Graceful stop: ENABLE deasserted at frame bit 10 -> frame completes (128 CLK total at BCLK_DIV = 2), then BCLK/LRCLK/SDATA = 0 and no further READ.
- Reset mid-frame: RESET asserted at frame bit 20 -> next cycle all outputs 0; after RESET drops with ENABLE = 1, the frame restarts at BIT_CNT = 0 with a fresh READ.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: mono I2S serializer fed directly by the sample FIFO read port.
//
// Each stereo frame fetches one sample. BCLK and LRCLK are divided down from CLK,
// and the sample is sent MSB-first on both the left and right slots with the usual
// one-BCLK I2S data delay. When a fetch finds the FIFO empty the frame sends
// silence, UNDERRUN pulses and a saturating counter increments.
//
// Ports:
//   CLK           system clock; also clocks the FIFO read side
//   RESET         synchronous, active-high reset
//   ENABLE        run request; a frame always completes once it has started
//   EMPTY         FIFO empty flag, sampled only in the fetch cycle
//   DIN           FIFO DOUT, which the FIFO updates on the falling CLK edge after a read
//   READ          FIFO read strobe, one CLK cycle wide, at most one per frame
//   BCLK          I2S bit clock
//   LRCLK         word select: 0 = left slot, 1 = right slot
//   SDATA         I2S serial data
//   UNDERRUN      one-cycle pulse when a fetch finds the FIFO empty
//   UNDERRUN_CNT  saturating underrun count
module i2s_tx #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SLOT_BITS = 16,
    parameter int unsigned BCLK_DIV  = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             EMPTY,
    input  logic [WIDTH-1:0] DIN,
    output logic             READ,
    output logic             BCLK,
    output logic             LRCLK,
    output logic             SDATA,
    output logic             UNDERRUN,
    output logic [7:0]       UNDERRUN_CNT
);

    localparam int unsigned DivW = $clog2(2 * BCLK_DIV);
    localparam int unsigned BitW = $clog2(2 * SLOT_BITS);
    localparam logic [DivW-1:0] DivMax = DivW'(2 * BCLK_DIV - 1);
    localparam logic [BitW-1:0] BitMax = BitW'(2 * SLOT_BITS - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [DivW-1:0]      div_q;
    logic [BitW-1:0]      bit_q;
    logic [BitW-1:0]      bit_nxt;
    logic [WIDTH-1:0]     sample_q;
    logic [SLOT_BITS-1:0] shift_q;
    logic [SLOT_BITS-1:0] slot_word;
    logic [1:0]           rd_pipe_q;
    logic [7:0]           urun_cnt_q;
    logic                 run;
    logic                 fetch;
    logic                 bit_wrap;
    logic                 frame_end;
    logic                 load;

    assign run       = (state_q == StRun);
    // RESET outranks the fetch, so no strobe can escape in the reset cycle.
    assign fetch     = run && (div_q == '0) && (bit_q == '0) && !RESET;
    assign bit_wrap  = run && (div_q == DivMax);
    assign frame_end = bit_wrap && (bit_q == BitMax);
    assign bit_nxt   = (bit_q == BitMax) ? '0 : bit_q + BitW'(1);
    // The shift register reloads one bit after each slot starts, which gives the I2S delay.
    assign load      = (bit_nxt == BitW'(1)) || (bit_nxt == BitW'(SLOT_BITS + 1));
    // Left-justify the sample in the slot and zero-pad below its LSB.
    assign slot_word = SLOT_BITS'(sample_q) << (SLOT_BITS - WIDTH);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. ENABLE is only considered at frame boundaries while running.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ENABLE) state_d = StRun;
            StRun:   if (frame_end && !ENABLE) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        READ         = fetch && !EMPTY;
        UNDERRUN     = fetch && EMPTY;
        BCLK         = run && (div_q >= DivW'(BCLK_DIV));
        LRCLK        = run && (bit_q >= BitW'(SLOT_BITS));
        SDATA        = run && shift_q[SLOT_BITS-1];
        UNDERRUN_CNT = urun_cnt_q;
    end

    // Datapath: counters, sample capture and shift register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q      <= '0;
            bit_q      <= '0;
            sample_q   <= '0;
            shift_q    <= '0;
            rd_pipe_q  <= '0;
            urun_cnt_q <= '0;
        end else begin
            rd_pipe_q <= {rd_pipe_q[0], READ};

            if (UNDERRUN) begin
                sample_q <= '0;
                if (urun_cnt_q != 8'hFF) urun_cnt_q <= urun_cnt_q + 8'd1;
            end else if (rd_pipe_q[1]) begin
                // DIN settles on the falling edge after the read; two cycles gives it margin.
                sample_q <= DIN;
            end

            if (!run || state_d != StRun) begin
                // Entering or leaving IDLE starts the next frame from a clean slate.
                div_q   <= '0;
                bit_q   <= '0;
                shift_q <= '0;
            end else if (bit_wrap) begin
                div_q <= '0;
                bit_q <= bit_nxt;
                if (load) begin
                    shift_q <= slot_word;
                end else begin
                    shift_q <= shift_q << 1;
                end
            end else begin
                div_q <= div_q + DivW'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with BCLK_DIV = 2: one bit period = 4 CLK, frame = 128 CLK.
module tb_i2s_tx;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic        empty = 1'b1;
    logic [15:0] din = 16'h0000;
    logic        READ, BCLK, LRCLK, SDATA, UNDERRUN;
    logic [7:0]  UNDERRUN_CNT;

    int checks = 0;
    int errors = 0;

    i2s_tx #(.WIDTH(16), .SLOT_BITS(16), .BCLK_DIV(2)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ENABLE       (ENABLE),
        .EMPTY        (empty),
        .DIN          (din),
        .READ         (READ),
        .BCLK         (BCLK),
        .LRCLK        (LRCLK),
        .SDATA        (SDATA),
        .UNDERRUN     (UNDERRUN),
        .UNDERRUN_CNT (UNDERRUN_CNT)
    );

    always #5 CLK = ~CLK;

    // FIFO model: a read seen in one cycle pops onto DOUT at the next falling edge.
    logic [15:0] fifo[$];
    logic        rd_seen = 1'b0;
    always @(negedge CLK) begin
        if (rd_seen && fifo.size() > 0) din = fifo.pop_front();
        rd_seen = READ;
        empty   = (fifo.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Frame word: bit 31 = SDATA at frame position 0, bit 0 = SDATA at position 31.
    function automatic logic [31:0] exp_frame(input logic [15:0] s, input logic prev);
        logic [31:0] w;
        w[31] = prev;
        for (int j = 0; j < 16; j++) w[30-j] = s[15-j];
        for (int j = 0; j < 15; j++) w[14-j] = s[15-j];
        return w;
    endfunction

    // Entered at frame cycle 0; returns at cycle 0 of the following frame.
    task automatic run_frame(output logic [31:0] sd_word, output int n_read, output int read_at,
                             output int n_urun, output int clk_err);
        sd_word = '0; n_read = 0; read_at = -1; n_urun = 0; clk_err = 0;
        for (int k = 0; k < 128; k++) begin
            if (READ) begin
                n_read++;
                read_at = k;
            end
            if (UNDERRUN) n_urun++;
            if (BCLK !== ((k % 4) >= 2)) clk_err++;
            if (LRCLK !== (k >= 64)) clk_err++;
            if ((k % 4) == 1) sd_word[31 - k/4] = SDATA;
            tick(1);
        end
    endtask

    task automatic do_frame(input string tag, input logic [15:0] s, input logic prev,
                            input bit expect_read);
        logic [31:0] sd;
        int nr, ra, nu, ce;
        run_frame(sd, nr, ra, nu, ce);
        check({tag, "_sdata"}, sd, exp_frame(s, prev));
        check({tag, "_reads"}, nr, expect_read ? 1 : 0);
        if (expect_read) check({tag, "_read_at"}, ra, 0);
        check({tag, "_urun"}, nu, expect_read ? 0 : 1);
        check({tag, "_clk_err"}, ce, 0);
    endtask

    initial begin
        int acc;
        int rds;

        // Reset behaviour.
        tick(3);
        RESET = 1'b0;
        acc = 0;
        rds = 0;
        for (int i = 0; i < 50; i++) begin
            if (BCLK || LRCLK || SDATA || UNDERRUN) acc++;
            if (READ) rds++;
            tick(1);
        end
        check("rst_outs", acc, 0);
        check("rst_reads", rds, 0);
        check("rst_cnt", UNDERRUN_CNT, 0);

        // Basic frame followed by stream ordering, then an underrun frame.
        fifo.push_back(16'hA5C3);
        fifo.push_back(16'h0001);
        fifo.push_back(16'h8000);
        fifo.push_back(16'hFFFF);
        tick(1);
        ENABLE = 1'b1;
        tick(1);
        do_frame("basic", 16'hA5C3, 1'b0, 1'b1);
        do_frame("s0001", 16'h0001, 1'b1, 1'b1);
        do_frame("s8000", 16'h8000, 1'b1, 1'b1);
        do_frame("sffff", 16'hFFFF, 1'b0, 1'b1);
        check("fifo_drained", fifo.size(), 0);
        do_frame("urun", 16'h0000, 1'b1, 1'b0);
        check("urun_cnt1", UNDERRUN_CNT, 1);

        // Saturation over a long run of empty frames.
        tick(253 * 128);
        check("urun_cnt254", UNDERRUN_CNT, 254);
        tick(128);
        check("urun_cnt255", UNDERRUN_CNT, 255);
        tick(46 * 128);
        check("urun_cnt_sat", UNDERRUN_CNT, 255);

        // Graceful stop: ENABLE drops at bit 10, the frame still runs to completion.
        tick(1);
        fifo.push_back(16'h8003);
        tick(127);
        check("stop_read", READ, 1);
        tick(40);
        ENABLE = 1'b0;
        tick(85);
        check("stop_sd_b31", SDATA, 1);
        tick(2);
        check("stop_bclk_c127", BCLK, 1);
        check("stop_lr_c127", LRCLK, 1);
        tick(1);
        fifo.push_back(16'h5555);
        acc = 0;
        rds = 0;
        for (int i = 0; i < 50; i++) begin
            if (BCLK || LRCLK || SDATA || UNDERRUN) acc++;
            if (READ) rds++;
            tick(1);
        end
        check("stop_idle_outs", acc, 0);
        check("stop_idle_reads", rds, 0);

        // Reset mid-frame, then a clean restart with a fresh read.
        ENABLE = 1'b1;
        tick(1);
        check("mid_read", READ, 1);
        fifo.push_back(16'h00FF);
        tick(80);
        RESET = 1'b1;
        tick(1);
        check("mid_rst_outs", {READ, BCLK, LRCLK, SDATA, UNDERRUN}, 5'b0);
        check("mid_rst_cnt", UNDERRUN_CNT, 0);
        RESET = 1'b0;
        tick(1);
        do_frame("restart", 16'h00FF, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
